// File: rtl/pc_stack_unit.sv
// Program counter with a two-entry return stack and skip/squash control.
// PC loads from stack, ALU or GOTO field; stack tracks depth and misuse.
module pc_stack_unit #(
    parameter int                  PC_WIDTH     = 9,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 9'h000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          pc_mux_select,
    input  logic                load_pc,
    input  logic                inc_pc,
    input  logic                load_stack,
    input  logic                inc_stack,
    input  logic                dec_stack,
    input  logic                skip_next_instruction,
    input  logic [7:0]          alu_result,
    input  logic [11:0]         instruction_reg_out,
    output logic [PC_WIDTH-1:0] pc,
    output logic [7:0]          pcl,
    output logic [PC_WIDTH-1:0] stack_top,
    output logic [1:0]          stack_depth,
    output logic                stack_overflow,
    output logic                stack_underflow,
    output logic                squash_ir
);

    logic [PC_WIDTH-1:0] stack [2];
    logic                sp;
    logic [PC_WIDTH-1:0] pc_next;
    logic                real_load;
    logic                unused_ir;

    assign unused_ir = ^instruction_reg_out[11:9];
    assign pcl       = pc[7:0];
    assign stack_top = stack[sp];
    // select 3 is a hold, so it must not cancel a pending skip
    assign real_load = load_pc && (pc_mux_select != 2'd3);

    // next PC: load beats increment, increment beats hold
    always_comb begin
        pc_next = pc;
        if (load_pc) begin
            unique case (pc_mux_select)
                2'd0:    pc_next = stack[sp];
                2'd1:    pc_next = PC_WIDTH'(alu_result);
                2'd2:    pc_next = PC_WIDTH'(instruction_reg_out[8:0]);
                default: pc_next = pc;
            endcase
        end else if (inc_pc) begin
            pc_next = pc + PC_WIDTH'(1);
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pc_next;
        end
    end

    // stack storage captures the PC before any same-cycle update
    always_ff @(posedge clk) begin
        if (!rst && load_stack) begin
            stack[sp] <= pc;
        end
    end

    // pointer, depth and sticky misuse flags; push+pop cancels
    always_ff @(posedge clk) begin
        if (rst) begin
            sp              <= 1'b0;
            stack_depth     <= 2'd0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (inc_stack && !dec_stack) begin
            sp <= ~sp;
            if (stack_depth == 2'd2) begin
                stack_overflow <= 1'b1;
            end else begin
                stack_depth <= stack_depth + 2'd1;
            end
        end else if (dec_stack && !inc_stack) begin
            sp <= ~sp;
            if (stack_depth == 2'd0) begin
                stack_underflow <= 1'b1;
            end else begin
                stack_depth <= stack_depth - 2'd1;
            end
        end
    end

    // squash lasts one inc_pc cycle; a squashed op cannot skip
    always_ff @(posedge clk) begin
        if (rst) begin
            squash_ir <= 1'b0;
        end else if (real_load) begin
            squash_ir <= 1'b0;
        end else if (inc_pc) begin
            if (squash_ir) begin
                squash_ir <= 1'b0;
            end else begin
                squash_ir <= skip_next_instruction;
            end
        end
    end

endmodule
